// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default widths, the
// reserved "no tag" value, the queued entry layout and source naming.
package cdb_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 6;

  // Tag value meaning "no producer"; an idle CDB drives this.
  localparam logic [CDB_TAG_W-1:0] NULL_TAG = '0;

  // One completed result as held in a source queue (tag above data).
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

  // Default assignment of producers to source indices.
  typedef enum logic [1:0] {
    SRC_INT  = 2'd0,
    SRC_MULT = 2'd1,
    SRC_DIV  = 2'd2,
    SRC_LSB  = 2'd3
  } cdb_src_e;

  // Round-robin successor of idx among n sources.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue. Power-of-two depth so read/write pointers wrap
// naturally; count is one bit wider than the pointers so "full" is exact.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && (count < DEPTH_C);
  assign do_pop  = pop  && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; entries arriving during reset or flush are dropped.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers each functional unit's results in its own
// queue, picks one non-empty queue per cycle by round-robin and broadcasts
// its head on a registered CDB.
//
// Handshake: a source offers a result by raising src_valid[i] with tag/data;
// it is accepted on a rising edge where src_valid[i] && src_ready[i]. While
// src_ready[i] is low the source must hold valid, tag and data unchanged.
// src_ready[i] depends only on the registered queue occupancy. The CDB side
// has no ready: CDB_valid marks a one-cycle broadcast consumers must take.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = CDB_DATA_W,
  parameter int TAG_WIDTH  = CDB_TAG_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag,
  output logic                          CDB_valid,
  output logic [DATA_WIDTH-1:0]         CDB_data,
  output logic [TAG_WIDTH-1:0]          CDB_tag,
  output logic [$clog2(NUM_SRC)-1:0]    CDB_src
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int EW    = TAG_WIDTH + DATA_WIDTH;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [EW-1:0]    head  [NUM_SRC];
  logic [CW-1:0]    count [NUM_SRC];
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_any;
  logic [EW-1:0]    grant_entry;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_ready[i] = (count[i] < DEPTH_C);
    assign req[i]       = (count[i] != '0);
    assign push[i]      = src_valid[i] && src_ready[i];

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push[i]),
      .wdata ({src_tag[i*TAG_WIDTH +: TAG_WIDTH], src_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .pop   (pop[i]),
      .head  (head[i]),
      .count (count[i])
    );
  end

  // Round-robin pick: first non-empty queue at or after rr_ptr, with wrap.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx[SRC_W-1:0];
      end
    end
  end

  // Pop exactly the granted queue's head.
  always_comb begin
    pop = '0;
    if (grant_any) pop[grant_idx] = 1'b1;
  end

  assign grant_entry = head[grant_idx];

  // Registered broadcast and round-robin pointer; flush keeps rr_ptr.
  always_ff @(posedge clk) begin
    if (reset) begin
      CDB_valid <= 1'b0;
      CDB_data  <= '0;
      CDB_tag   <= TAG_WIDTH'(NULL_TAG);
      CDB_src   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      CDB_valid <= 1'b0;
      CDB_data  <= '0;
      CDB_tag   <= TAG_WIDTH'(NULL_TAG);
    end else if (grant_any) begin
      CDB_valid <= 1'b1;
      CDB_data  <= grant_entry[DATA_WIDTH-1:0];
      CDB_tag   <= grant_entry[EW-1 -: TAG_WIDTH];
      CDB_src   <= grant_idx;
      rr_ptr    <= SRC_W'(rr_next(int'(grant_idx), NUM_SRC));
    end else begin
      CDB_valid <= 1'b0;
      CDB_data  <= '0;
      CDB_tag   <= TAG_WIDTH'(NULL_TAG);
    end
  end

endmodule
